hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It sits beside the datapath and owns forwarding selects, stall/flush generation and exception redirect. It adds two things to the plain combinational hazard logic: a register scoreboard that tracks outstanding long-latency writes (divider, multi-cycle units), and a registered exception-redirect FSM that holds the redirect while a data-memory access is still in flight.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_scoreboard.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types/constants for the hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef logic [1:0] exc_state_t;
  localparam exc_state_t ST_IDLE     = 2'd0;
  localparam exc_state_t ST_HOLD     = 2'd1;
  localparam exc_state_t ST_REDIRECT = 2'd2;

  localparam logic [31:0] ERET_CODE = 32'h0000_000E;

  localparam logic [1:0] FWD_E_RF = 2'b00;
  localparam logic [1:0] FWD_E_W  = 2'b01;
  localparam logic [1:0] FWD_E_M  = 2'b10;

  localparam logic [1:0] FWD_D_RF   = 2'b00;
  localparam logic [1:0] FWD_D_M    = 2'b01;
  localparam logic [1:0] FWD_D_LONG = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Pending-write bits and outstanding count for long-latency ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              clr_all,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              rs_pend,
  output logic              rt_pend,
  output logic              full
);
  import hazard_pkg::*;

  localparam int               NREG    = 2 ** REG_AW;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);

  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  pend_nxt;
  logic [CNT_W-1:0] pend_cnt;

  // Set is applied after clear so a same-register collision leaves the bit set.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_addr] = 1'b0;
    if (set_en) pend_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend <= pend_nxt;
      if (set_en && !clr_en)
        pend_cnt <= pend_cnt + CNT_ONE;
      else if (clr_en && !set_en && pend_cnt != '0)
        pend_cnt <= pend_cnt - CNT_ONE;
    end
  end

  assign rs_pend = pend[rs_addr];
  assign rt_pend = pend[rt_addr];
  assign full    = (pend_cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Forwarding, stall/flush and exception redirect for the 5-stage
//            core. Optional HAZARD_LONG_FWD_EN adds a long-result decode bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int          REG_AW     = 5,
  parameter int          MAX_PEND   = 4,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              longD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] reg_waddrE,
  input  logic              regwriteE,
  input  logic              memtoRegE,
  input  logic              longE,
  input  logic [REG_AW-1:0] reg_waddrM,
  input  logic [REG_AW-1:0] reg_waddrW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoRegM,
  input  logic              long_done,
  input  logic [REG_AW-1:0] long_waddr,
  input  logic              mem_busyM,
  input  logic [31:0]       excepttypeM,
  input  logic [31:0]       cp0_epcM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
`ifdef HAZARD_LONG_FWD_EN
  output logic [1:0]        forwardAD,
  output logic [1:0]        forwardBD,
`else
  output logic              forwardAD,
  output logic              forwardBD,
`endif
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              long_cancel,
  output logic              pc_redirect,
  output logic [31:0]       newpcM
);
  import hazard_pkg::*;

  exc_state_t  state;
  exc_state_t  state_nxt;
  logic        latch_pc;
  logic        redirect;
  logic        exc_hold;
  logic        exc_req;
  logic [31:0] target;
  logic        lu_stall;
  logic        br_stall;
  logic        sb_stall;
  logic        rs_pend;
  logic        rt_pend;
  logic        sb_full;
  logic        sb_set;
  logic        rs_bypass;
  logic        rt_bypass;

  always_comb begin
    forwardAE = FWD_E_RF;
    if (regwriteM && reg_waddrM != '0 && reg_waddrM == rsE)      forwardAE = FWD_E_M;
    else if (regwriteW && reg_waddrW != '0 && reg_waddrW == rsE) forwardAE = FWD_E_W;
    forwardBE = FWD_E_RF;
    if (regwriteM && reg_waddrM != '0 && reg_waddrM == rtE)      forwardBE = FWD_E_M;
    else if (regwriteW && reg_waddrW != '0 && reg_waddrW == rtE) forwardBE = FWD_E_W;
  end

`ifdef HAZARD_LONG_FWD_EN
  // The completing long result is on the regfile write port this cycle.
  assign rs_bypass = long_done && long_waddr == rsD;
  assign rt_bypass = long_done && long_waddr == rtD;

  always_comb begin
    forwardAD = FWD_D_RF;
    if (regwriteM && reg_waddrM != '0 && reg_waddrM == rsD)      forwardAD = FWD_D_M;
    else if (long_done && long_waddr != '0 && long_waddr == rsD) forwardAD = FWD_D_LONG;
    forwardBD = FWD_D_RF;
    if (regwriteM && reg_waddrM != '0 && reg_waddrM == rtD)      forwardBD = FWD_D_M;
    else if (long_done && long_waddr != '0 && long_waddr == rtD) forwardBD = FWD_D_LONG;
  end
`else
  assign rs_bypass = 1'b0;
  assign rt_bypass = 1'b0;
  assign forwardAD = regwriteM && reg_waddrM != '0 && reg_waddrM == rsD;
  assign forwardBD = regwriteM && reg_waddrM != '0 && reg_waddrM == rtD;
`endif

  assign lu_stall = memtoRegE && (rsD == rtE || rtD == rtE) && rtE != '0;
  assign br_stall = (branchD || jrD) &&
                    ((regwriteE && (rsD == reg_waddrE || rtD == reg_waddrE)) ||
                     (memtoRegM && (rsD == reg_waddrM || rtD == reg_waddrM)));

  assign sb_set = longE && regwriteE && !stallE && reg_waddrE != '0;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .MAX_PEND (MAX_PEND)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (reg_waddrE),
    .clr_en   (long_done),
    .clr_addr (long_waddr),
    .clr_all  (redirect),
    .rs_addr  (rsD),
    .rt_addr  (rtD),
    .rs_pend  (rs_pend),
    .rt_pend  (rt_pend),
    .full     (sb_full)
  );

  assign sb_stall = (rs_pend && !rs_bypass) || (rt_pend && !rt_bypass) || (longD && sb_full);

  assign exc_req = excepttypeM != '0;
  assign target  = (excepttypeM == ERET_CODE) ? cp0_epcM : EXC_VECTOR;

  always_comb begin
    state_nxt = state;
    latch_pc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exc_req && !mem_busyM) begin
          state_nxt = ST_REDIRECT;
          latch_pc  = 1'b1;
        end else if (exc_req) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!mem_busyM) begin
          state_nxt = ST_REDIRECT;
          latch_pc  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      newpcM <= EXC_VECTOR;
    end else begin
      state <= state_nxt;
      if (latch_pc) newpcM <= target;
    end
  end

  assign redirect = (state == ST_REDIRECT);
  assign exc_hold = (state == ST_HOLD);

  assign stallF      = lu_stall || br_stall || sb_stall || exc_hold || mem_busyM;
  assign stallD      = stallF;
  assign stallE      = mem_busyM;
  assign stallM      = mem_busyM;
  assign flushD      = redirect;
  assign flushE      = ((lu_stall || br_stall || sb_stall) && !mem_busyM) || redirect;
  assign flushM      = redirect;
  assign long_cancel = redirect;
  assign pc_redirect = redirect;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (HAZARD_LONG_FWD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  localparam int S_FAE = 0, S_FBE = 1, S_FAD = 2, S_FBD = 3, S_STF = 4, S_STD = 5,
                 S_STE = 6, S_STM = 7, S_FLD = 8, S_FLE = 9, S_FLM = 10, S_LC = 11,
                 S_PCR = 12, S_NPC = 13;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, reg_waddrE, reg_waddrM, reg_waddrW, long_waddr;
  logic branchD, jrD, longD, regwriteE, memtoRegE, longE;
  logic regwriteM, regwriteW, memtoRegM, long_done, mem_busyM;
  logic [31:0] excepttypeM, cp0_epcM;
  logic [1:0]  forwardAE, forwardBE;
`ifdef HAZARD_LONG_FWD_EN
  logic [1:0]  forwardAD, forwardBD;
`else
  logic        forwardAD, forwardBD;
`endif
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, long_cancel, pc_redirect;
  logic [31:0] newpcM;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD), .longD(longD),
    .rsE(rsE), .rtE(rtE), .reg_waddrE(reg_waddrE), .regwriteE(regwriteE),
    .memtoRegE(memtoRegE), .longE(longE), .reg_waddrM(reg_waddrM), .reg_waddrW(reg_waddrW),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .memtoRegM(memtoRegM),
    .long_done(long_done), .long_waddr(long_waddr), .mem_busyM(mem_busyM),
    .excepttypeM(excepttypeM), .cp0_epcM(cp0_epcM), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .long_cancel(long_cancel),
    .pc_redirect(pc_redirect), .newpcM(newpcM)
  );

  function automatic logic [31:0] obs(input int id);
    case (id)
      S_FAE:   return 32'(forwardAE);
      S_FBE:   return 32'(forwardBE);
      S_FAD:   return 32'(forwardAD);
      S_FBD:   return 32'(forwardBD);
      S_STF:   return 32'(stallF);
      S_STD:   return 32'(stallD);
      S_STE:   return 32'(stallE);
      S_STM:   return 32'(stallM);
      S_FLD:   return 32'(flushD);
      S_FLE:   return 32'(flushE);
      S_FLM:   return 32'(flushM);
      S_LC:    return 32'(long_cancel);
      S_PCR:   return 32'(pc_redirect);
      default: return newpcM;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input int id, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = val;
    q.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then advance past the next edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, obs(e.id), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0; reg_waddrE = '0; reg_waddrM = '0;
    reg_waddrW = '0; long_waddr = '0;
    branchD = 0; jrD = 0; longD = 0; regwriteE = 0; memtoRegE = 0; longE = 0;
    regwriteM = 0; regwriteW = 0; memtoRegM = 0; long_done = 0; mem_busyM = 0;
    excepttypeM = '0; cp0_epcM = '0;
  endtask

  task automatic issue_long(input logic [REG_AW-1:0] r);
    idle();
    longE = 1; regwriteE = 1; reg_waddrE = r;
    cycle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state
    expect_out("rst_stallF", S_STF, 0);
    expect_out("rst_flushE", S_FLE, 0);
    expect_out("rst_pcr", S_PCR, 0);
    expect_out("rst_lc", S_LC, 0);
    expect_out("rst_npc", S_NPC, VEC);
    expect_out("rst_fae", S_FAE, 0);
    cycle();

    // load-use: lw $2 in E, add $3,$2,$4 in D
    idle();
    rsD = 2; rtD = 4; memtoRegE = 1; regwriteE = 1; rtE = 2; reg_waddrE = 2;
    expect_out("lu_stallF", S_STF, 1);
    expect_out("lu_stallD", S_STD, 1);
    expect_out("lu_flushE", S_FLE, 1);
    expect_out("lu_stallE", S_STE, 0);
    cycle();
    idle();
    rsD = 2; rtD = 4; memtoRegM = 1; regwriteM = 1; reg_waddrM = 2;
    expect_out("lu_release", S_STF, 0);
    cycle();
    idle();
    rsE = 2; rtE = 4; regwriteW = 1; reg_waddrW = 2;
    expect_out("lu_fwdAE_W", S_FAE, 1);
    expect_out("lu_fwdBE", S_FBE, 0);
    cycle();
    idle();
    rsE = 2; rtE = 2; regwriteW = 1; reg_waddrW = 2; regwriteM = 1; reg_waddrM = 2;
    expect_out("fwdAE_Mprio", S_FAE, 2);
    expect_out("fwdBE_Mprio", S_FBE, 2);
    cycle();
    idle();
    regwriteM = 1; regwriteW = 1;
    expect_out("fwdAE_r0", S_FAE, 0);
    expect_out("fwdAD_r0", S_FAD, 0);
    cycle();

    // branch hazards
    idle();
    branchD = 1; rsD = 3; regwriteE = 1; reg_waddrE = 3;
    expect_out("br_E_stall", S_STF, 1);
    expect_out("br_E_flushE", S_FLE, 1);
    cycle();
    idle();
    jrD = 1; rsD = 1; rtD = 6; memtoRegM = 1; regwriteM = 1; reg_waddrM = 6;
    expect_out("jr_M_stall", S_STF, 1);
    cycle();
    idle();
    rsD = 1; rtD = 6; regwriteM = 1; reg_waddrM = 6;
    expect_out("nobr_stall", S_STF, 0);
    expect_out("fwdBD_M", S_FBD, 1);
    expect_out("fwdAD_none", S_FAD, 0);
    cycle();

    // scoreboard: div writes $5, consumer of $5 waits for completion
    issue_long(5);
    idle();
    rsD = 5;
    expect_out("sb_stall", S_STF, 1);
    expect_out("sb_flushE", S_FLE, 1);
    cycle();
    idle();
    rsD = 5; long_done = 1; long_waddr = 5;
`ifdef HAZARD_LONG_FWD_EN
    expect_out("sb_done_stall", S_STF, 0);
    expect_out("sb_done_fwdAD", S_FAD, 2);
`else
    expect_out("sb_done_stall", S_STF, 1);
`endif
    cycle();
    idle();
    rsD = 5;
    expect_out("sb_after_done", S_STF, 0);
    cycle();

    // fill to MAX_PEND
    issue_long(8);
    issue_long(9);
    issue_long(10);
    issue_long(11);
    idle();
    longD = 1;
    expect_out("full_stall", S_STF, 1);
    cycle();
    idle();
    longD = 1; long_done = 1; long_waddr = 8;
    expect_out("full_stall_done", S_STF, 1);
    cycle();
    idle();
    longD = 1;
    expect_out("not_full", S_STF, 0);
    cycle();
    idle();
    longE = 1; regwriteE = 1; reg_waddrE = 7; long_done = 1; long_waddr = 7;
    cycle();
    idle();
    rtD = 7;
    expect_out("setclr_bit7", S_STF, 1);
    cycle();
    idle();
    longD = 1;
    expect_out("setclr_cnt", S_STF, 0);
    cycle();
    issue_long(12);
    idle();
    longD = 1;
    expect_out("refull_stall", S_STF, 1);
    cycle();

    // exception, no memory busy
    idle();
    excepttypeM = 32'h1;
    expect_out("exc_pcr0", S_PCR, 0);
    cycle();
    idle();
    longE = 1; regwriteE = 1; reg_waddrE = 9;
    expect_out("exc_pcr", S_PCR, 1);
    expect_out("exc_npc", S_NPC, VEC);
    expect_out("exc_flushD", S_FLD, 1);
    expect_out("exc_flushE", S_FLE, 1);
    expect_out("exc_flushM", S_FLM, 1);
    expect_out("exc_lc", S_LC, 1);
    cycle();
    idle();
    rsD = 9; rtD = 7; longD = 1;
    expect_out("exc_sb_clear", S_STF, 0);
    expect_out("exc_pcr_off", S_PCR, 0);
    cycle();

    // ERET with memory busy for 3 cycles
    for (int i = 0; i < 3; i++) begin
      idle();
      excepttypeM = 32'hE; cp0_epcM = 32'h8000_1000; mem_busyM = 1;
      expect_out("eret_hold_stallF", S_STF, 1);
      expect_out("eret_hold_stallM", S_STM, 1);
      expect_out("eret_hold_pcr", S_PCR, 0);
      cycle();
    end
    idle();
    excepttypeM = 32'hE; cp0_epcM = 32'h8000_1000;
    expect_out("eret_hold_last", S_STF, 1);
    expect_out("eret_hold_pcr2", S_PCR, 0);
    expect_out("eret_hold_stallE", S_STE, 0);
    cycle();
    idle();
    expect_out("eret_pcr", S_PCR, 1);
    expect_out("eret_npc", S_NPC, 32'h8000_1000);
    cycle();

    // reset during HOLD
    idle();
    excepttypeM = 32'h1; mem_busyM = 1;
    cycle();
    idle();
    excepttypeM = 32'h1; mem_busyM = 1; rst = 1;
    cycle();
    rst = 0;
    idle();
    expect_out("rsthold_pcr", S_PCR, 0);
    expect_out("rsthold_stallF", S_STF, 0);
    expect_out("rsthold_npc", S_NPC, VEC);
    expect_out("rsthold_flushD", S_FLD, 0);
    cycle();
    idle();
    expect_out("rsthold_pcr2", S_PCR, 0);
    expect_out("rsthold_lc", S_LC, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
